// File: rtl/franken_mmio_pkg.sv
// Shared constants and types for the data-side memory/MMIO block.
// Address map, status bit positions and UART FSM states.
package franken_mmio_pkg;

  localparam logic [31:0] MMIO_BASE     = 32'h8000_0000;
  localparam logic [31:0] LED_OFF       = 32'h0000_0000;
  localparam logic [31:0] UART_DATA_OFF = 32'h0000_0004;
  localparam logic [31:0] UART_STAT_OFF = 32'h0000_0008;
  localparam logic [31:0] CYCLE_OFF     = 32'h0000_000C;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/franken_uart_tx.sv
// 8N1 UART transmitter with a small TX FIFO.
// tx is registered; the shifter loads straight from the FIFO on pop.
module franken_uart_tx
  import franken_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW:0]   wr_q;
  logic [PW:0]   rd_q;
  logic          pop;
  logic          do_push;

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  assign count   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop     = (state_q == IDLE) && !empty;
  // a pop frees the slot the push lands in, so full+pop still accepts
  assign do_push = push && (!full || pop);
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wr_q[PW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = START;
          baud_d  = BAUD_MAX;
          shift_d = fifo_q[rd_q[PW-1:0]];
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          state_d = DATA;
          baud_d  = BAUD_MAX;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else if (bit_q == 3'd7) begin
          state_d = STOP;
          baud_d  = BAUD_MAX;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 1'b1;
          baud_d  = BAUD_MAX;
          shift_d = {1'b0, shift_q[7:1]};
          tx_d    = shift_q[1];
        end
      end
      STOP: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/franken_dmem_mmio.sv
// Data memory plus MMIO page (LEDs, cycle counter, UART) for the core.
// Loads are combinational; stores commit on the rising edge.
module franken_dmem_mmio
  import franken_mmio_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0]   ram_q [RAM_WORDS];
  logic [AW-1:0] idx;
  logic          is_ram;
  logic          sel_led;
  logic          sel_udata;
  logic          sel_stat;
  logic          sel_cyc;

  logic [7:0]    leds_q, leds_d;
  logic [31:0]   cycle_q, cycle_d;

  logic          uart_push;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_busy;
  logic [PW:0]   tx_cnt;
  logic [31:0]   cnt32;
  logic [31:0]   stat;

  assign idx       = addr[AW+1:2];
  assign is_ram    = !addr[31];
  assign sel_led   = (addr == MMIO_BASE + LED_OFF);
  assign sel_udata = (addr == MMIO_BASE + UART_DATA_OFF);
  assign sel_stat  = (addr == MMIO_BASE + UART_STAT_OFF);
  assign sel_cyc   = (addr == MMIO_BASE + CYCLE_OFF);
  assign uart_push = mem_write && sel_udata && byte_enable[0];

  always_ff @(posedge clk) begin
    if (mem_write && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enable[i]) ram_q[idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    leds_d = leds_q;
    if (mem_write && sel_led && byte_enable[0]) leds_d = write_data[7:0];
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (mem_write && sel_cyc && |byte_enable) cycle_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q  <= '0;
      cycle_q <= '0;
    end else begin
      leds_q  <= leds_d;
      cycle_q <= cycle_d;
    end
  end

  franken_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart (
    .clk       (clk),
    .reset     (reset),
    .push      (uart_push),
    .push_data (write_data[7:0]),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_cnt),
    .busy      (tx_busy),
    .tx        (uart_tx)
  );

  always_comb begin
    cnt32 = 32'(tx_cnt);
    stat  = '0;
    stat[ST_BUSY]  = tx_busy;
    stat[ST_FULL]  = tx_full;
    stat[ST_EMPTY] = tx_empty;
    stat[ST_CNT_LSB +: 4] = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];
  end

  always_comb begin
    read_data = '0;
    unique case (1'b1)
      is_ram:   read_data = ram_q[idx];
      sel_led:  read_data = {24'b0, leds_q};
      sel_stat: read_data = stat;
      sel_cyc:  read_data = cycle_q;
      default:  read_data = '0;
    endcase
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_franken_dmem_mmio.sv
// Directed bench for franken_dmem_mmio: RAM, LEDs, cycle counter, UART.
// CLKS_PER_BIT=4 so a full frame is 40 cycles.
module tb_franken_dmem_mmio;
  import franken_mmio_pkg::*;

  localparam logic [31:0] A_LED   = MMIO_BASE + LED_OFF;
  localparam logic [31:0] A_UDATA = MMIO_BASE + UART_DATA_OFF;
  localparam logic [31:0] A_STAT  = MMIO_BASE + UART_STAT_OFF;
  localparam logic [31:0] A_CYC   = MMIO_BASE + CYCLE_OFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [3:0]  byte_enable;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  leds;
  logic        uart_tx;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  franken_dmem_mmio #(
    .RAM_WORDS    (1024),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_write   (mem_write),
    .byte_enable (byte_enable),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .leds        (leds),
    .uart_tx     (uart_tx)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    @(negedge clk);
    mem_write   = 1'b1;
    addr        = a;
    write_data  = d;
    byte_enable = be;
    @(negedge clk);
    mem_write   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    mem_write = 1'b0;
    addr      = a;
    #1;
    check(tag, read_data, exp);
  endtask

  task automatic expect_frame(input logic [7:0] b, input bit chk_busy,
                              output int waited);
    logic [9:0] fr;
    bit         found;
    logic       e;
    fr     = {1'b1, b, 1'b0};
    waited = 0;
    found  = 1'b0;
    while (!found && waited < 200) begin
      @(negedge clk);
      waited++;
      if (uart_tx === 1'b0) found = 1'b1;
    end
    if (!found) begin
      check("frame start timeout", {31'b0, uart_tx}, 32'd0);
      return;
    end
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge clk);
      e = fr[j/4];
      check($sformatf("tx %02h cyc %0d", b, j), {31'b0, uart_tx},
            {31'b0, e});
      if (chk_busy) check("busy in frame", {31'b0, read_data[ST_BUSY]}, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int lows;
    reset       = 1'b1;
    mem_write   = 1'b0;
    byte_enable = 4'h0;
    addr        = '0;
    write_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    rd("reset cycle", A_CYC, 32'd0);
    check("reset tx", {31'b0, uart_tx}, 32'd1);
    check("reset leds", {24'b0, leds}, 32'd0);
    rd("reset status", A_STAT, 32'h04);
    rd("reset led read", A_LED, 32'd0);

    store(32'h10, 32'hDEAD_BEEF, 4'b1111);
    rd("ram word", 32'h10, 32'hDEAD_BEEF);
    store(32'h10, 32'h0000_AB00, 4'b0010);
    rd("ram lane1", 32'h10, 32'hDEAD_ABEF);
    store(32'h10, 32'h1200_0000, 4'b1000);
    rd("ram lane3", 32'h10, 32'h12AD_ABEF);
    store(32'h10, 32'hFFFF_FFFF, 4'b0000);
    rd("ram be0", 32'h10, 32'h12AD_ABEF);
    rd("ram alias", 32'h1010, 32'h12AD_ABEF);
    store(32'h14, 32'hCAFE_F00D, 4'b1111);
    rd("ram next word", 32'h14, 32'hCAFE_F00D);
    rd("ram neighbour", 32'h10, 32'h12AD_ABEF);

    @(negedge clk);
    mem_write   = 1'b1;
    addr        = A_LED;
    write_data  = 32'h1A5;
    byte_enable = 4'b1111;
    #1;
    check("led pre-edge read", read_data, 32'd0);
    @(negedge clk);
    mem_write = 1'b0;
    check("leds port", {24'b0, leds}, 32'hA5);
    rd("led read", A_LED, 32'hA5);
    store(A_LED, 32'h77, 4'b1110);
    check("led be0 off", {24'b0, leds}, 32'hA5);
    store(32'h8000_0020, 32'hFFFF_FFFF, 4'b1111);
    check("unmapped store", {24'b0, leds}, 32'hA5);
    rd("unmapped read", 32'h8000_0020, 32'd0);
    rd("udata read", A_UDATA, 32'd0);

    @(negedge clk);
    addr = A_CYC;
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    check("cycle forced", read_data, 32'hFFFF_FFFF);
    check("cycle wrap next", dut.cycle_d, 32'd0);
    release dut.cycle_q;
    store(A_CYC, 32'h1234, 4'b1111);
    rd("cycle N+1", A_CYC, 32'd0);
    @(negedge clk);
    rd("cycle N+2", A_CYC, 32'd1);
    @(negedge clk);
    rd("cycle N+3", A_CYC, 32'd2);

    store(A_UDATA, 32'h55, 4'b1111);
    addr = A_STAT;
    expect_frame(8'h55, 1'b1, w);
    check("frame latency", w, 32'd1);
    @(negedge clk);
    rd("status after frame", A_STAT, 32'h04);
    check("tx idle after frame", {31'b0, uart_tx}, 32'd1);

    @(negedge clk);
    fork
      begin
        for (int i = 1; i <= 10; i++) begin
          mem_write   = 1'b1;
          addr        = A_UDATA;
          write_data  = i;
          byte_enable = 4'b1111;
          @(negedge clk);
        end
        mem_write = 1'b0;
        addr      = A_STAT;
        #1;
        check("status full", read_data, 32'h83);
      end
      begin
        int fw;
        for (int f = 1; f <= 9; f++) begin
          expect_frame(8'(f), 1'b0, fw);
          if (f > 1) check($sformatf("gap before %0d", f), fw, 32'd2);
        end
      end
    join
    @(negedge clk);
    rd("status drained", A_STAT, 32'h04);
    check("tx idle drained", {31'b0, uart_tx}, 32'd1);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("no 10th frame", lows, 32'd0);

    for (int i = 0; i < 4; i++) begin
      mem_write   = 1'b1;
      addr        = A_UDATA;
      write_data  = (i == 0) ? 32'h08 : 32'h20 + i;
      byte_enable = 4'b1111;
      @(negedge clk);
    end
    mem_write = 1'b0;
    addr      = A_STAT;
    repeat (15) @(negedge clk);
    #1;
    check("tx bit3 pre-reset", {31'b0, uart_tx}, 32'd1);
    check("status pre-reset", read_data, 32'h31);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("tx after reset", {31'b0, uart_tx}, 32'd1);
    check("status after reset", read_data, 32'h04);
    check("leds after reset", {24'b0, leds}, 32'd0);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("no frames after reset", lows, 32'd0);
    rd("status quiet", A_STAT, 32'h04);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
